mantissa_divider_24bit: RTL and testbench

//  Iterative restoring divider for IEEE-754 single-precision mantissas. It is the division

---
 rtl/fp_div_pkg.sv | 26 ++
 rtl/mantissa_divider_24bit_div_step.sv | 27 ++
 rtl/mantissa_divider_24bit.sv | 116 +++++++++++
 tb/tb_mantissa_divider_24bit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the single-precision mantissa divider.
//   MAN_W  : fraction width per operand, hidden bit excluded
//   Q_W    : quotient width; three bits beyond MAN_W remain for rounding
//   CNT_W  : width of the iteration counter
//   N_W    : width of a mantissa with its hidden bit prepended
//   R_W    : width of the partial remainder and of the compare/subtract
//   div_state_t : divider FSM encoding
// ---------------------------------------------------------------------------
package fp_div_pkg;

    localparam int MAN_W = 23;
    localparam int Q_W   = 26;
    localparam int CNT_W = $clog2(Q_W);
    localparam int N_W   = MAN_W + 1;
    // The partial remainder stays below 2*D, so it needs one bit more than D.
    localparam int R_W   = MAN_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/mantissa_divider_24bit_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
//   r      in  R_W  current partial remainder
//   d      in  N_W  divisor with hidden bit
//   q_bit  out 1    quotient bit produced by this iteration (r >= d)
//   r_next out R_W  remainder after the conditional subtract, before doubling
// ---------------------------------------------------------------------------
module div_step
    import fp_div_pkg::*;
(
    input  logic [R_W-1:0] r,
    input  logic [N_W-1:0] d,
    output logic           q_bit,
    output logic [R_W-1:0] r_next
);

    logic [R_W-1:0] d_ext;
    logic [R_W-1:0] diff;

    // Divisor is zero-extended so the compare and subtract share one width.
    assign d_ext  = {1'b0, d};
    assign diff   = r - d_ext;
    assign q_bit  = (r >= d_ext);
    assign r_next = q_bit ? diff : r;

endmodule

// File: rtl/mantissa_divider_24bit.sv
// ---------------------------------------------------------------------------
// mantissa_divider_24bit
// Iterative restoring divider for IEEE-754 single-precision mantissas,
// producing one quotient bit per clock.
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operands present on man_a/man_b
//   in_ready   out  1      divider idle and able to take operands
//   man_a      in   MAN_W  dividend fraction (hidden 1 added here)
//   man_b      in   MAN_W  divisor fraction (hidden 1 added here)
//   out_valid  out  1      result available, held until consumed
//   out_ready  in   1      downstream takes the result
//   quotient   out  Q_W    floor(({1,man_a} << (Q_W-1)) / {1,man_b})
//   MSB_bit    out  1      quotient MSB: 1 when the ratio is >= 1.0
//   sticky     out  1      final remainder nonzero (inexact)
// ---------------------------------------------------------------------------
module mantissa_divider_24bit
    import fp_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   quotient,
    output logic             MSB_bit,
    output logic             sticky
);

    div_state_t       state;
    div_state_t       next_state;
    logic [R_W-1:0]   rem;
    logic [N_W-1:0]   divisor;
    logic [Q_W-1:0]   quot;
    logic [CNT_W-1:0] cnt;
    logic             sticky_reg;
    logic             step_q;
    logic [R_W-1:0]   step_r;

    // Single shared iteration stage; the loop is unrolled over time.
    div_step u_step (
        .r      (rem),
        .d      (divisor),
        .q_bit  (step_q),
        .r_next (step_r)
    );

    // State register; reset discards any in-flight division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: accept in IDLE, iterate Q_W times in RUN, and hold
    // the result in DONE until downstream takes it.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (in_valid)           next_state = RUN;
            RUN:  if (cnt == '0)          next_state = DONE;
            DONE: if (out_ready)          next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, and the
    // sticky flag taken from the undoubled final remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem        <= '0;
            divisor    <= '0;
            quot       <= '0;
            cnt        <= '0;
            sticky_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem        <= {2'b01, man_a};
                        divisor    <= {1'b1, man_b};
                        quot       <= '0;
                        cnt        <= CNT_W'(Q_W - 1);
                        sticky_reg <= 1'b0;
                    end
                end
                RUN: begin
                    quot <= {quot[Q_W-2:0], step_q};
                    if (cnt != '0) begin
                        // step_r < D < 2^(N_W), so its MSB is zero and
                        // doubling cannot overflow R_W bits.
                        rem <= {step_r[R_W-2:0], 1'b0};
                        cnt <= cnt - 1'b1;
                    end else begin
                        rem        <= step_r;
                        sticky_reg <= (step_r != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quot;
    assign MSB_bit   = quot[Q_W-1];
    assign sticky    = sticky_reg;

endmodule

// File: tb/tb_mantissa_divider_24bit.sv
// ---------------------------------------------------------------------------
// tb_mantissa_divider_24bit
// Scoreboard bench for the mantissa divider: expected results are queued at
// operand acceptance and popped when the divider presents a result.
// ---------------------------------------------------------------------------
module tb_mantissa_divider_24bit;
    import fp_div_pkg::*;

    typedef struct packed {
        logic [Q_W-1:0] q;
        logic           msb;
        logic           sticky;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic             out_valid;
    logic             out_ready;
    logic [Q_W-1:0]   quotient;
    logic             MSB_bit;
    logic             sticky;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    mantissa_divider_24bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .man_a     (man_a),
        .man_b     (man_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .MSB_bit   (MSB_bit),
        .sticky    (sticky)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: long division on wide integers.
    function automatic exp_t refModel(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b);
        logic [63:0] n;
        logic [63:0] d;
        logic [63:0] num;
        logic [63:0] q;
        exp_t        e;
        n        = {40'd0, 1'b1, a};
        d        = {40'd0, 1'b1, b};
        num      = n << (Q_W - 1);
        q        = num / d;
        e.q      = q[Q_W-1:0];
        e.msb    = q[Q_W-1];
        e.sticky = ((num % d) != 64'd0);
        return e;
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waits (bounded) for in_ready, presents operands for one edge and queues
    // the expected result. Returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b);
        bit ready_seen;
        ready_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ready_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("in_ready_seen", 64'(ready_seen), 64'd1);
        man_a    = a;
        man_b    = b;
        in_valid = 1'b1;
        sb.push_back(refModel(a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid counting edges from the accepting edge
    // (that edge counted as 1), compares against the scoreboard, optionally
    // holds out_ready low while poking in_valid, then consumes the result.
    task automatic collectResult(input bit check_latency, input int hold_cycles);
        int   edges;
        bit   seen;
        exp_t e;
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("out_valid_seen", 64'(seen), 64'd1);
        if (check_latency)
            checkOutput("latency", 64'(edges), 64'(Q_W + 1));
        checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0)
            return;
        e = sb.pop_front();
        checkOutput("quotient", 64'(quotient), 64'(e.q));
        checkOutput("MSB_bit", 64'(MSB_bit), 64'(e.msb));
        checkOutput("sticky", 64'(sticky), 64'(e.sticky));
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = k[0];
            man_a    = MAN_W'($urandom);
            man_b    = MAN_W'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_quotient", 64'(quotient), 64'(e.q));
            checkOutput("hold_MSB_bit", 64'(MSB_bit), 64'(e.msb));
            checkOutput("hold_sticky", 64'(sticky), 64'(e.sticky));
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("in_ready_after", 64'(in_ready), 64'd1);
        checkOutput("out_valid_after", 64'(out_valid), 64'd0);
    endtask

    // Main sequence: reset state, directed ratios, back-pressure, mid-run
    // reset, then random operand pairs.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        man_a        = '0;
        man_b        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_MSB_bit", 64'(MSB_bit), 64'd0);
        checkOutput("reset_sticky", 64'(sticky), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1/1, 1/1.5, 1.5/1, max/1 and ratio extremes.
        applyStimulus(23'h000000, 23'h000000);
        collectResult(1'b1, 0);
        applyStimulus(23'h000000, 23'h400000);
        collectResult(1'b1, 0);
        applyStimulus(23'h400000, 23'h000000);
        collectResult(1'b1, 0);
        applyStimulus(23'h7FFFFF, 23'h000000);
        collectResult(1'b1, 0);
        applyStimulus(23'h000000, 23'h7FFFFF);
        collectResult(1'b1, 0);
        applyStimulus(23'h7FFFFF, 23'h7FFFFF);
        collectResult(1'b1, 0);

        // Back-pressure for 10 cycles with in_valid pokes.
        applyStimulus(23'h400000, 23'h000000);
        collectResult(1'b1, 10);
        checkOutput("no_extra_accept", 64'(sb.size()), 64'd0);

        // Reset in the seventh RUN cycle discards the operation.
        applyStimulus(23'h000000, 23'h000000);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_quotient", 64'(quotient), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(23'h000000, 23'h400000);
        collectResult(1'b1, 0);

        // Random operand pairs.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(MAN_W'($urandom), MAN_W'($urandom));
            collectResult(1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
